// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, operand width and requester-ID width.
package alu_pkg;

  localparam int unsigned DataW = 64;
  localparam int unsigned IdW   = 1;
  localparam int unsigned OpW   = 3;

  typedef enum logic [OpW-1:0] {
    OpAnd  = 3'b000,
    OpOr   = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpSlt  = 3'b100,
    OpXor  = 3'b101,
    OpAddi = 3'b110,
    OpRsvd = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational 64-bit ALU; the zero flag always reflects (a - b) == 0, whatever the op.
module alu
  import alu_pkg::*;
(
  input  logic [OpW-1:0]   op_i,
  input  logic [DataW-1:0] a_i,
  input  logic [DataW-1:0] b_i,
  output logic [DataW-1:0] result_o,
  output logic             zero_o
);

  logic [DataW-1:0] diff;
  logic             lt;

  assign diff   = a_i - b_i;
  assign lt     = $signed(a_i) < $signed(b_i);
  assign zero_o = (diff == '0);

  always_comb begin
    result_o = '0;
    case (alu_op_e'(op_i))
      OpAnd:          result_o = a_i & b_i;
      OpOr:           result_o = a_i | b_i;
      OpAdd, OpAddi:  result_o = a_i + b_i;
      OpSub:          result_o = diff;
      OpSlt:          result_o = {{(DataW-1){1'b0}}, lt};
      OpXor:          result_o = a_i ^ b_i;
      default:        result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter of two requesters onto one shared ALU, with results queued in a
// small FIFO tagged by requester ID.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [OpW-1:0]   req0_op,
  input  logic [OpW-1:0]   req1_op,
  input  logic [DataW-1:0] req0_a,
  input  logic [DataW-1:0] req0_b,
  input  logic [DataW-1:0] req1_a,
  input  logic [DataW-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IdW-1:0]   rsp_id,
  output logic [DataW-1:0] rsp_result,
  output logic             rsp_zero
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             last_q, last_d;
  logic [DataW-1:0] res_q  [DEPTH];
  logic [IdW-1:0]   id_q   [DEPTH];
  logic             zero_q [DEPTH];

  logic             can_push, push, pop;
  logic [OpW-1:0]   alu_op;
  logic [DataW-1:0] alu_a, alu_b, alu_result;
  logic             alu_zero;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // last_q names the requester granted most recently; the other one wins a tie.
  assign can_push   = count_q < CntW'(DEPTH);
  assign req0_ready = !rst && can_push && req0_valid && (!req1_valid || last_q);
  assign req1_ready = !rst && can_push && req1_valid && (!req0_valid || !last_q);
  assign push       = req0_ready || req1_ready;
  assign rsp_valid  = (count_q != '0);
  assign pop        = rsp_valid && rsp_ready;

  assign alu_op = req1_ready ? req1_op : req0_op;
  assign alu_a  = req1_ready ? req1_a  : req0_a;
  assign alu_b  = req1_ready ? req1_b  : req0_b;

  alu u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  assign rsp_id     = id_q[rd_ptr_q];
  assign rsp_result = res_q[rd_ptr_q];
  assign rsp_zero   = zero_q[rd_ptr_q];

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    last_d   = push ? req1_ready : last_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
        res_q[i]  <= '0;
        id_q[i]   <= '0;
        zero_q[i] <= 1'b0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
      if (push) begin
        res_q[wr_ptr_q]  <= alu_result;
        id_q[wr_ptr_q]   <= req1_ready;
        zero_q[wr_ptr_q] <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-based behavioural model.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic        rsp_id;
  logic [63:0] rsp_result;
  logic        rsp_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        id;
    logic [63:0] res;
    logic        z;
  } ent_t;

  ent_t mq[$];
  int   m_last = 1;
  logic acc0 = 1'b0, acc1 = 1'b0;

  function automatic logic [63:0] ref_alu(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd5:    return a ^ b;
      3'd6:    return a + b;
      default: return 64'd0;
    endcase
  endfunction

  // Which requester the spec's rules accept this cycle, or -1 for none.
  function automatic int winner();
    if (mq.size() >= 2) return -1;
    if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_last = 1;
      acc0 = 1'b0;
      acc1 = 1'b0;
    end else begin
      int   w;
      ent_t e;
      w = winner();
      acc0 = (w == 0);
      acc1 = (w == 1);
      if (mq.size() > 0 && rsp_ready) void'(mq.pop_front());
      if (w == 0) begin
        e.id = 1'b0; e.res = ref_alu(req0_op, req0_a, req0_b); e.z = (req0_a == req0_b);
        mq.push_back(e);
        m_last = 0;
      end else if (w == 1) begin
        e.id = 1'b1; e.res = ref_alu(req1_op, req1_a, req1_b); e.z = (req1_a == req1_b);
        mq.push_back(e);
        m_last = 1;
      end
    end
  end

  // Inputs only change on the falling edge, so 2 time units after the rising edge both the
  // registered state and the combinational readies are settled and comparable.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
      chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    end else begin
      int w;
      w = winner();
      chk("m_ready0", {63'd0, req0_ready}, {63'd0, (w == 0)});
      chk("m_ready1", {63'd0, req1_ready}, {63'd0, (w == 1)});
      chk("m_rsp_valid", {63'd0, rsp_valid}, {63'd0, (mq.size() != 0)});
      if (mq.size() != 0) begin
        chk("m_rsp_id", {63'd0, rsp_id}, {63'd0, mq[0].id});
        chk("m_rsp_result", rsp_result, mq[0].res);
        chk("m_rsp_zero", {63'd0, rsp_zero}, {63'd0, mq[0].z});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set0(input logic v, input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // One isolated req0 transaction on an empty buffer, checked against literals.
  task automatic single(input string name, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] er, input logic ez);
    @(negedge clk);
    rsp_ready = 1'b1;
    set0(1'b1, op, a, b);
    #1 chk({name, "_ready"}, {63'd0, req0_ready}, 64'd1);
    @(posedge clk);
    #2;
    chk({name, "_valid"}, {63'd0, rsp_valid}, 64'd1);
    chk({name, "_id"}, {63'd0, rsp_id}, 64'd0);
    chk({name, "_result"}, rsp_result, er);
    chk({name, "_zero"}, {63'd0, rsp_zero}, {63'd0, ez});
    @(negedge clk);
    req0_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_result", rsp_result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single request and arithmetic edges
    single("t1_add", 3'd2, 64'd5, 64'd7, 64'd12, 1'b0);
    single("t4_slt", 3'd4, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 1'b0);
    single("t4_sub", 3'd3, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    single("t4_add_wrap", 3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    single("t4_rsvd", 3'd7, 64'd3, 64'd3, 64'd0, 1'b1);
    single("t4_addi", 3'd6, 64'd10, 64'd3, 64'd13, 1'b0);
    single("t4_xor", 3'd5, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0);

    // Contention: grants alternate 0,1,0,1
    do_reset();
    @(negedge clk);
    rsp_ready = 1'b1;
    set0(1'b1, 3'd2, 64'd100, 64'd1);
    set1(1'b1, 3'd3, 64'd200, 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if ((i - 1) % 2 == 0) req0_a = req0_a + 64'd10;
        else req1_a = req1_a + 64'd10;
      end
      #1;
      chk("t2_grant0", {63'd0, req0_ready}, {63'd0, (i % 2 == 0)});
      chk("t2_grant1", {63'd0, req1_ready}, {63'd0, (i % 2 == 1)});
    end
    drain();

    // Full buffer: two accepted, third waits for a pop
    do_reset();
    @(negedge clk);
    set0(1'b1, 3'd0, 64'hFF, 64'h0F);
    set1(1'b1, 3'd1, 64'hF0, 64'h0F);
    #1 chk("t3_first0", {63'd0, req0_ready}, 64'd1);
    @(negedge clk);
    set0(1'b1, 3'd5, 64'h33, 64'h11);
    #1 chk("t3_second1", {63'd0, req1_ready}, 64'd1);
    chk("t3_second0", {63'd0, req0_ready}, 64'd0);
    @(negedge clk);
    req1_valid = 1'b0;
    #1 chk("t3_full0", {63'd0, req0_ready}, 64'd0);
    chk("t3_full1", {63'd0, req1_ready}, 64'd0);
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 chk("t3_popcycle0", {63'd0, req0_ready}, 64'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 chk("t3_third0", {63'd0, req0_ready}, 64'd1);
    drain();

    // Reset mid-stream with two results buffered
    do_reset();
    @(negedge clk);
    set0(1'b1, 3'd2, 64'd1, 64'd1);
    set1(1'b1, 3'd2, 64'd2, 64'd2);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("t5_async_valid", {63'd0, rsp_valid}, 64'd0);
    chk("t5_async_ready0", {63'd0, req0_ready}, 64'd0);
    chk("t5_async_ready1", {63'd0, req1_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("t5_first0", {63'd0, req0_ready}, 64'd1);
    chk("t5_first1", {63'd0, req1_ready}, 64'd0);
    @(posedge clk);
    #2 chk("t5_id", {63'd0, rsp_id}, 64'd0);
    chk("t5_result", rsp_result, 64'd2);
    drain();

    // Simultaneous push and pop at count 1
    do_reset();
    @(negedge clk);
    set0(1'b1, 3'd0, 64'hF, 64'h3);
    @(negedge clk);
    req0_valid = 1'b0;
    set1(1'b1, 3'd3, 64'd100, 64'd58);
    rsp_ready = 1'b1;
    #1 chk("t6_ready1", {63'd0, req1_ready}, 64'd1);
    @(posedge clk);
    #2 chk("t6_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t6_id", {63'd0, rsp_id}, 64'd1);
    chk("t6_result", rsp_result, 64'd42);
    @(negedge clk);
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    #1 chk("t6_still_one", {63'd0, rsp_valid}, 64'd1);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 chk("t6_empty", {63'd0, rsp_valid}, 64'd0);
    rsp_ready = 1'b0;

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op    = 3'($urandom);
        req0_a     = {$urandom, $urandom};
        req0_b     = ($urandom_range(0, 7) == 0) ? req0_a : {$urandom, $urandom};
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op    = 3'($urandom);
        req1_a     = {$urandom, $urandom};
        req1_b     = ($urandom_range(0, 7) == 0) ? req1_a : {$urandom, $urandom};
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
